// File: rtl/nth_root_pkg.sv
// Shared types and sizing helpers for the iterative n-th root engine.
// Widths are derived from the radicand width, fraction bits and max degree.
package nth_root_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        MUL,
        CMP,
        DONE
    } state_t;

    function automatic int calc_out_w(input int in_w, input int frac_w);
        return in_w + frac_w;
    endfunction

    function automatic int calc_pw(input int n_max, input int out_w);
        return n_max * out_w;
    endfunction

    function automatic int shift_amt(input int n, input int frac_w);
        return n * frac_w;
    endfunction

endpackage

// File: rtl/root_pow_mul.sv
// Registered power accumulator: acc <= acc * trial once per enabled cycle.
// done flags that the step now executing is the final one.
module root_pow_mul #(
    parameter int OUT_W = 20,
    parameter int PW    = 140,
    parameter int N_W   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [OUT_W-1:0] trial,
    input  logic [N_W-1:0]   cnt_init,
    output logic [PW-1:0]    acc,
    output logic             done
);

    logic [N_W-1:0] cnt;

    assign done = (cnt == N_W'(1));

    // Load trial as the first power, then multiply in one factor per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (load) begin
            acc <= PW'(trial);
            cnt <= cnt_init;
        end else if (en) begin
            acc <= acc * PW'(trial);
            cnt <= cnt - N_W'(1);
        end
    end

endmodule

// File: rtl/nth_root_iter.sv
// Bit-serial n-th root: one result bit per SETUP/MUL/CMP pass, MSB first.
// A trial bit is kept when trial^n does not exceed x scaled by 2^(n*FRAC_W).
module nth_root_iter
    import nth_root_pkg::*;
#(
    parameter int IN_W   = 10,
    parameter int FRAC_W = 10,
    parameter int N_W    = 3,
    parameter int N_MAX  = 7,
    localparam int OUT_W = calc_out_w(IN_W, FRAC_W),
    localparam int PW    = calc_pw(N_MAX, OUT_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data_1,
    input  logic [N_W-1:0]   in_data_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err
);

    localparam int PTR_W = $clog2(OUT_W);
    localparam int NSZ   = 2 ** N_W;
    // Bit i set when degree i is legal (1..N_MAX).
    localparam logic [NSZ-1:0] LEGAL =
        NSZ'((64'd1 << (N_MAX + 1)) - 64'd2);

    state_t state;
    state_t nxt;

    logic [N_W-1:0]   n_r;
    logic [N_W-1:0]   cnt_init;
    logic [PW-1:0]    target;
    logic [PW-1:0]    acc;
    logic [OUT_W-1:0] root;
    logic [OUT_W-1:0] bit_m;
    logic [OUT_W-1:0] trial;
    logic [PTR_W-1:0] ptr;
    logic             mul_load;
    logic             mul_en;
    logic             mul_last;
    logic             legal;
    logic             hit;
    logic             exact;
    logic             last_bit;
    logic             finish;

    assign bit_m    = OUT_W'(1) << ptr;
    assign trial    = root | bit_m;
    assign legal    = LEGAL[in_data_2];
    assign hit      = (acc <= target);
    assign exact    = (acc == target);
    assign last_bit = (ptr == '0);
    assign finish   = exact || last_bit;
    assign cnt_init = n_r - N_W'(1);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    root_pow_mul #(
        .OUT_W(OUT_W),
        .PW   (PW),
        .N_W  (N_W)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (mul_load),
        .en      (mul_en),
        .trial   (trial),
        .cnt_init(cnt_init),
        .acc     (acc),
        .done    (mul_last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // Next-state and multiplier control.
    always_comb begin
        nxt      = state;
        mul_load = 1'b0;
        mul_en   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) nxt = legal ? SETUP : DONE;
            end
            SETUP: begin
                mul_load = 1'b1;
                nxt = (n_r == N_W'(1)) ? CMP : MUL;
            end
            MUL: begin
                mul_en = 1'b1;
                if (mul_last) nxt = CMP;
            end
            CMP: begin
                nxt = finish ? DONE : SETUP;
            end
            DONE: begin
                if (out_ready) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Operand capture, root/pointer update and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_r      <= '0;
            target   <= '0;
            root     <= '0;
            ptr      <= '0;
            out_data <= '0;
            out_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        n_r    <= in_data_2;
                        target <= PW'(in_data_1)
                                  << shift_amt(int'(in_data_2), FRAC_W);
                        root   <= '0;
                        ptr    <= PTR_W'(OUT_W - 1);
                        if (!legal) begin
                            out_data <= '0;
                            out_err  <= 1'b1;
                        end
                    end
                end
                CMP: begin
                    if (hit) root <= trial;
                    if (finish) begin
                        out_data <= hit ? trial : root;
                        out_err  <= 1'b0;
                    end else begin
                        ptr <= ptr - PTR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nth_root_iter.sv
// Directed plus random checks of nth_root_iter against a binary-search root model.
// Latency is counted in clock edges after the accepting edge.
module tb_nth_root_iter;

    localparam int IN_W   = 10;
    localparam int FRAC_W = 10;
    localparam int N_W    = 3;
    localparam int N_MAX  = 7;
    localparam int OUT_W  = IN_W + FRAC_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_data_1 = '0;
    logic [N_W-1:0]   in_data_2 = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out_data;
    logic             out_err;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nth_root_iter #(
        .IN_W  (IN_W),
        .FRAC_W(FRAC_W),
        .N_W   (N_W),
        .N_MAX (N_MAX)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data_1(in_data_1),
        .in_data_2(in_data_2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_err  (out_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [159:0] ipow(input longint r, input int n);
        logic [159:0] p;
        p = 160'd1;
        for (int i = 0; i < n; i++) p = p * 160'(r);
        return p;
    endfunction

    // Largest r with r^n <= x * 2^(n*FRAC_W), found by bisection.
    function automatic longint ref_root(input int x, input int n);
        logic [159:0] t;
        longint lo, hi, mid;
        t  = 160'(x) << (n * FRAC_W);
        lo = 0;
        hi = longint'(1) << OUT_W;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (ipow(mid, n) <= t) lo = mid;
            else hi = mid;
        end
        return lo;
    endfunction

    task automatic do_op(input int x, input int n, input int hold);
        longint er;
        logic   legal;
        logic   exact;
        int     elat;
        int     lat;
        int     tz;
        logic [OUT_W-1:0] held;
        legal = (n >= 1) && (n <= N_MAX);
        er    = 0;
        elat  = 0;
        if (legal) begin
            er    = ref_root(x, n);
            exact = (er != 0) &&
                    (ipow(er, n) == (160'(x) << (n * FRAC_W)));
            tz = 0;
            if (exact) while (((er >> tz) & 1) == 0) tz++;
            elat = (OUT_W - tz) * (n + 1);
        end
        @(negedge clk);
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        in_data_1 = IN_W'(x);
        in_data_2 = N_W'(n);
        @(posedge clk);
        #1;
        lat = 0;
        while (!out_valid && lat < 300) begin
            in_data_1 = IN_W'($urandom);
            in_data_2 = N_W'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        chk("out_valid", 64'(out_valid), 64'd1);
        chk("latency", 64'(lat), 64'(elat));
        chk("out_data", 64'(out_data), 64'(er));
        chk("out_err", 64'(out_err), 64'(!legal));
        chk("in_ready_busy", 64'(in_ready), 64'd0);
        held = out_data;
        repeat (hold) begin
            in_data_1 = IN_W'($urandom);
            in_data_2 = N_W'($urandom);
            @(posedge clk);
            #1;
        end
        if (hold > 0) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'(out_data), 64'(held));
            chk("hold_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("valid_drop", 64'(out_valid), 64'd0);
        chk("no_accept", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        chk("data_keep", 64'(out_data), 64'(held));
    endtask

    initial begin
        #3;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(8, 3, 0);
        chk("x8n3", 64'(out_data), 64'h00800);
        do_op(2, 2, 0);
        chk("x2n2", 64'(out_data), 64'h005A8);
        do_op(1023, 1, 0);
        chk("x1023n1", 64'(out_data), 64'hFFC00);
        do_op(0, 5, 0);
        chk("x0n5", 64'(out_data), 64'h00000);
        do_op(1000, 7, 10);
        chk("x1000n7", 64'(out_data), 64'h00ABB);
        do_op(5, 0, 0);
        chk("n0_err", 64'(out_err), 64'd1);
        do_op(81, 4, 0);
        chk("n4_clear", 64'(out_err), 64'd0);
        chk("x81n4", 64'(out_data), 64'h00C00);

        for (int i = 0; i < 24; i++)
            do_op(int'($urandom_range(0, 1023)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 3)));

        do_op(1023, 1, 0);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data_1 = IN_W'(1000);
        in_data_2 = N_W'(7);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_data", 64'(out_data), 64'd0);
        chk("abort_err", 64'(out_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16, 4, 0);
        chk("x16n4", 64'(out_data), 64'h00800);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
